// File: rtl/cla_multislice_add_ctrl_if.sv
// rtl/cla_multislice_add_ctrl_if.sv - requester/controller handshake and operand/result bundle
interface cla_multislice_add_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             op_sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output start, op_sub, A, B, cin,
    input  busy, done, sum, cout, overflow, zero
  );

  modport slave (
    input  start, op_sub, A, B, cin,
    output busy, done, sum, cout, overflow, zero
  );
endinterface

// File: rtl/cla_multislice_add_ctrl.sv
// rtl/cla_multislice_add_ctrl.sv - WIDTH-bit add/sub by iterating one 4-bit CLA slice LSB first
module cla4_slice (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       p_o,
  output logic       g_o
);
  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  assign c[0] = c_i;
  assign c[1] = g[0] | (p[0] & c_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);

  assign s_o = p ^ c;
  assign p_o = &p;
  assign g_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
endmodule

module cla_multislice_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  cla_multislice_add_ctrl_if.slave     bus
);
  localparam int NSLICE = WIDTH / 4;
  localparam int IDXW   = $clog2(NSLICE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] bop_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic             carry_q;
  logic             carry_d;
  logic [IDXW-1:0]  idx_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  logic [3:0]       s_sum;
  logic             s_p;
  logic             s_g;
  logic             last;

  // Slice operands come only from captured registers, never from the bus.
  cla4_slice u_slice (
    .a_i (a_q[{idx_q, 2'b00} +: 4]),
    .b_i (bop_q[{idx_q, 2'b00} +: 4]),
    .c_i (carry_q),
    .s_o (s_sum),
    .p_o (s_p),
    .g_o (s_g)
  );

  assign carry_d = s_g | (s_p & carry_q);
  assign last    = (idx_q == IDXW'(NSLICE - 1));

  always_comb begin
    acc_d = acc_q;
    acc_d[{idx_q, 2'b00} +: 4] = s_sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      bop_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            a_q     <= bus.A;
            bop_q   <= bus.op_sub ? ~bus.B : bus.B;
            carry_q <= bus.op_sub | bus.cin;
            acc_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          acc_q   <= acc_d;
          carry_q <= carry_d;
          if (last) begin
            // Results are published in one shot so partial nibbles never appear.
            idx_q   <= '0;
            done_q  <= 1'b1;
            sum_q   <= acc_d;
            cout_q  <= carry_d;
            ovf_q   <= (a_q[WIDTH-1] == bop_q[WIDTH-1]) & (acc_d[WIDTH-1] != a_q[WIDTH-1]);
            zero_q  <= (acc_d == '0);
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
  assign bus.zero     = zero_q;
endmodule
